// File: rtl/sprite_ctrl_pkg.sv
// rtl/sprite_ctrl_pkg.sv - shared states, screen geometry and step width for the sprite controller
package sprite_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVING = 2'd1,
      POPPED = 2'd2
   } state_e;

   localparam int SCREEN_W_PX    = 1280;
   localparam int SCREEN_H_PX    = 720;
   localparam int SPRITE_W_PX    = 256;
   localparam int SPRITE_H_PX    = 256;
   localparam int SPAWN_X        = 512;
   localparam int SPAWN_Y        = 232;
   localparam int POP_FRAMES_DEF = 30;

   localparam int STEP_W = 12;
   localparam int SPD_W  = 4;
   localparam int X_W    = 11;
   localparam int Y_W    = 10;

endpackage

// File: rtl/bounce_axis.sv
// rtl/bounce_axis.sv - one axis of bouncing motion: position, direction, step/clamp/flip
module bounce_axis
   import sprite_ctrl_pkg::*;
#(
   parameter int MAX   = 1024,
   parameter int INIT  = 512,
   parameter int OUT_W = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step_en,
   input  logic             respawn,
   input  logic [SPD_W-1:0] spd_in,
   output logic [OUT_W-1:0] pos_out
);

   localparam logic signed [STEP_W-1:0] MAX_S  = STEP_W'(MAX);
   localparam logic signed [STEP_W-1:0] ZERO_S = '0;

   logic [OUT_W-1:0]         pos_q, pos_d;
   logic                     dir_neg_q, dir_neg_d;
   logic signed [STEP_W-1:0] pos_s, spd_s, n;

   always_comb begin
      pos_d     = pos_q;
      dir_neg_d = dir_neg_q;
      pos_s     = {{(STEP_W-OUT_W){1'b0}}, pos_q};
      spd_s     = {{(STEP_W-SPD_W){1'b0}}, spd_in};
      n         = dir_neg_q ? pos_s - spd_s : pos_s + spd_s;
      if (respawn) begin
         pos_d     = OUT_W'(INIT);
         dir_neg_d = 1'b0;
      end else if (step_en && spd_in != '0) begin
         // zero speed is excluded above so a stationary sprite never flips
         if (n >= MAX_S) begin
            pos_d     = OUT_W'(MAX);
            dir_neg_d = 1'b1;
         end else if (n <= ZERO_S) begin
            pos_d     = '0;
            dir_neg_d = 1'b0;
         end else begin
            pos_d = n[OUT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pos_q     <= OUT_W'(INIT);
         dir_neg_q <= 1'b0;
      end else begin
         pos_q     <= pos_d;
         dir_neg_q <= dir_neg_d;
      end
   end

   assign pos_out = pos_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// rtl/sprite_motion_ctrl.sv - per-frame sprite motion, pop timing and respawn control
module sprite_motion_ctrl
   import sprite_ctrl_pkg::*;
#(
   parameter int WIDTH      = SPRITE_W_PX,
   parameter int HEIGHT     = SPRITE_H_PX,
   parameter int SCREEN_W   = SCREEN_W_PX,
   parameter int SCREEN_H   = SCREEN_H_PX,
   parameter int X0         = SPAWN_X,
   parameter int Y0         = SPAWN_Y,
   parameter int POP_FRAMES = POP_FRAMES_DEF
) (
   input  logic             pixel_clk_in,
   input  logic             rst_n_in,
   input  logic             new_frame_in,
   input  logic             enable_in,
   input  logic [SPD_W-1:0] dx_in,
   input  logic [SPD_W-1:0] dy_in,
   input  logic             pop_trigger_in,
   output logic [X_W-1:0]   x_out,
   output logic [Y_W-1:0]   y_out,
   output logic             pop_out,
   output logic             popping_out
);

   localparam int CNT_W = (POP_FRAMES > 1) ? $clog2(POP_FRAMES) : 1;

   state_e           state_q, state_d;
   logic             latch_q, latch_d;
   logic             pop_q, pop_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hit, step_en, respawn;

   always_comb begin
      state_d = state_q;
      pop_d   = pop_q;
      cnt_d   = cnt_q;
      step_en = 1'b0;
      respawn = 1'b0;
      // a trigger coinciding with the frame pulse counts for this update
      hit     = latch_q | pop_trigger_in;
      latch_d = hit;
      if (new_frame_in) begin
         latch_d = 1'b0;
         case (state_q)
            IDLE: begin
               if (enable_in) state_d = MOVING;
            end
            MOVING: begin
               if (hit) begin
                  state_d = POPPED;
                  pop_d   = 1'b1;
                  cnt_d   = CNT_W'(POP_FRAMES - 1);
               end else if (!enable_in) begin
                  state_d = IDLE;
               end else begin
                  step_en = 1'b1;
               end
            end
            POPPED: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - 1'b1;
               end else begin
                  respawn = 1'b1;
                  pop_d   = 1'b0;
                  state_d = MOVING;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge pixel_clk_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
         latch_q <= 1'b0;
         pop_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         latch_q <= latch_d;
         pop_q   <= pop_d;
         cnt_q   <= cnt_d;
      end
   end

   bounce_axis #(.MAX(SCREEN_W - WIDTH), .INIT(X0), .OUT_W(X_W)) u_axis_x (
      .clk     (pixel_clk_in),
      .rst_n   (rst_n_in),
      .step_en (step_en),
      .respawn (respawn),
      .spd_in  (dx_in),
      .pos_out (x_out)
   );

   bounce_axis #(.MAX(SCREEN_H - HEIGHT), .INIT(Y0), .OUT_W(Y_W)) u_axis_y (
      .clk     (pixel_clk_in),
      .rst_n   (rst_n_in),
      .step_en (step_en),
      .respawn (respawn),
      .spd_in  (dy_in),
      .pos_out (y_out)
   );

   assign pop_out     = pop_q;
   assign popping_out = (state_q == POPPED);

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb/tb_sprite_motion_ctrl.sv - directed and randomized checks of sprite_motion_ctrl against a frame-level model
module tb_sprite_motion_ctrl;

   localparam int X0   = 512;
   localparam int Y0   = 232;
   localparam int XMAX = 1024;
   localparam int YMAX = 464;
   localparam int PF   = 30;

   localparam int M_IDLE = 0;
   localparam int M_MOVE = 1;
   localparam int M_POP  = 2;

   logic        clk = 1'b0;
   logic        rst_n_in;
   logic        new_frame_in;
   logic        enable_in;
   logic [3:0]  dx_in;
   logic [3:0]  dy_in;
   logic        pop_trigger_in;
   logic [10:0] x_out;
   logic [9:0]  y_out;
   logic        pop_out;
   logic        popping_out;

   int n_vec = 0;
   int n_err = 0;

   int mx, my, mmode, mcnt;
   bit mxn, myn, mlatch, mpop;

   always #5 clk = ~clk;

   sprite_motion_ctrl dut (
      .pixel_clk_in   (clk),
      .rst_n_in       (rst_n_in),
      .new_frame_in   (new_frame_in),
      .enable_in      (enable_in),
      .dx_in          (dx_in),
      .dy_in          (dy_in),
      .pop_trigger_in (pop_trigger_in),
      .x_out          (x_out),
      .y_out          (y_out),
      .pop_out        (pop_out),
      .popping_out    (popping_out)
   );

   function automatic void step_axis(input int p, input bit neg, input int spd, input int lim,
                                     output int np, output bit nneg);
      int n;
      np   = p;
      nneg = neg;
      if (spd != 0) begin
         n = neg ? p - spd : p + spd;
         if (n >= lim) begin
            np = lim; nneg = 1'b1;
         end else if (n <= 0) begin
            np = 0; nneg = 1'b0;
         end else begin
            np = n;
         end
      end
   endfunction

   function automatic void model_reset();
      mx = X0; my = Y0; mxn = 1'b0; myn = 1'b0;
      mmode = M_IDLE; mcnt = 0; mlatch = 1'b0; mpop = 1'b0;
   endfunction

   function automatic void model_frame(input bit en, input int dx, input int dy, input bit trig);
      bit hit;
      int nx, ny;
      bit nxn, nyn;
      hit    = mlatch | trig;
      mlatch = 1'b0;
      if (mmode == M_IDLE) begin
         if (en) mmode = M_MOVE;
      end else if (mmode == M_MOVE) begin
         if (hit) begin
            mmode = M_POP; mpop = 1'b1; mcnt = PF - 1;
         end else if (!en) begin
            mmode = M_IDLE;
         end else begin
            step_axis(mx, mxn, dx, XMAX, nx, nxn);
            step_axis(my, myn, dy, YMAX, ny, nyn);
            mx = nx; mxn = nxn; my = ny; myn = nyn;
         end
      end else begin
         if (mcnt != 0) begin
            mcnt = mcnt - 1;
         end else begin
            mx = X0; my = Y0; mxn = 1'b0; myn = 1'b0; mpop = 1'b0; mmode = M_MOVE;
         end
      end
   endfunction

   task automatic chk(input string tag);
      bit exp_popping;
      exp_popping = (mmode == M_POP);
      n_vec++;
      assert (x_out === 11'(mx) && y_out === 10'(my) && pop_out === mpop && popping_out === exp_popping)
      else begin
         n_err++;
         $error("FAIL %s: x=%0d exp %0d, y=%0d exp %0d, pop=%b exp %b, popping=%b exp %b",
                tag, x_out, mx, y_out, my, pop_out, mpop, popping_out, exp_popping);
      end
   endtask

   task automatic chk_int(input string tag, input logic [31:0] obs, input int exp);
      n_vec++;
      assert (obs === 32'(exp))
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic frame(input bit en, input int dx, input int dy, input bit trig);
      chk("pre_frame");
      enable_in      = en;
      dx_in          = 4'(dx);
      dy_in          = 4'(dy);
      pop_trigger_in = trig;
      new_frame_in   = 1'b1;
      @(negedge clk);
      new_frame_in   = 1'b0;
      pop_trigger_in = 1'b0;
      model_frame(en, dx, dy, trig);
      chk("post_frame");
      @(negedge clk);
      chk("frame_hold");
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("gap_hold");
      end
   endtask

   task automatic pulse_trig();
      pop_trigger_in = 1'b1;
      mlatch         = 1'b1;
      @(negedge clk);
      pop_trigger_in = 1'b0;
      chk("trig_hold");
   endtask

   task automatic do_reset();
      rst_n_in = 1'b0;
      @(negedge clk);
      model_reset();
      chk("reset");
      rst_n_in = 1'b1;
   endtask

   initial begin
      int hi, guard, fx, fy;
      bit en, trig;
      rst_n_in       = 1'b0;
      new_frame_in   = 1'b0;
      enable_in      = 1'b0;
      dx_in          = '0;
      dy_in          = '0;
      pop_trigger_in = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset_init");
      chk_int("reset_x", x_out, 512);
      chk_int("reset_y", y_out, 232);
      rst_n_in = 1'b1;

      frame(1'b0, 4, 2, 1'b0);
      frame(1'b0, 4, 2, 1'b0);
      chk_int("idle_x", x_out, 512);
      chk_int("idle_y", y_out, 232);

      repeat (4) frame(1'b1, 4, 2, 1'b0);
      chk_int("motion_x", x_out, 524);
      chk_int("motion_y", y_out, 238);

      guard = 0;
      while (mx != 1020 && guard < 200) begin
         frame(1'b1, (1020 - mx > 15) ? 15 : 1020 - mx, 0, 1'b0);
         guard++;
      end
      chk_int("reach_x1020", x_out, 1020);
      frame(1'b1, 8, 0, 1'b0);
      chk_int("clamp_x", x_out, 1024);
      frame(1'b1, 8, 0, 1'b0);
      chk_int("bounce_x", x_out, 1016);

      guard = 0;
      while (!(my == 3 && myn) && guard < 200) begin
         frame(1'b1, 0, myn ? ((my - 3 > 15) ? 15 : my - 3) : 15, 1'b0);
         guard++;
      end
      chk_int("reach_y3", y_out, 3);
      frame(1'b1, 0, 5, 1'b0);
      chk_int("clamp_y", y_out, 0);
      frame(1'b1, 0, 5, 1'b0);
      chk_int("bounce_y", y_out, 5);
      chk_int("still_x", x_out, 1016);

      pulse_trig();
      gap(100);
      fx = mx;
      fy = my;
      frame(1'b1, 3, 3, 1'b0);
      chk_int("pop_enter", pop_out, 1);
      hi = pop_out ? 1 : 0;
      guard = 0;
      while (pop_out === 1'b1 && guard < 40) begin
         if (guard == 5) pulse_trig();
         frame(1'b1, 3, 3, 1'b0);
         if (pop_out === 1'b1) begin
            hi++;
            chk_int("frozen_x", x_out, fx);
            chk_int("frozen_y", y_out, fy);
         end
         guard++;
      end
      chk_int("pop_frames", hi, 30);
      chk_int("respawn_x", x_out, 512);
      chk_int("respawn_y", y_out, 232);
      chk_int("respawn_pop", pop_out, 0);

      frame(1'b1, 2, 2, 1'b1);
      chk_int("simul_popping", popping_out, 1);
      repeat (10) frame(1'b1, 2, 2, 1'b0);
      do_reset();
      chk_int("midpop_rst_pop", pop_out, 0);
      chk_int("midpop_rst_popping", popping_out, 0);
      chk_int("midpop_rst_x", x_out, 512);

      repeat (300) begin
         en   = ($urandom_range(0, 9) != 0);
         trig = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 19) == 0) pulse_trig();
         gap($urandom_range(0, 3));
         frame(en, $urandom_range(0, 15), $urandom_range(0, 15), trig);
         if ($urandom_range(0, 149) == 0) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
